ccff_bitstream_loader: RTL and testbench

- Upstream feeder for the tile configuration chain. It accepts configuration words over a valid/ready handshake and serialises them, one bit per shift, into the chain head port `ccff_head` of the first grid/tile.
- It drives a shift enable that the prog-clock gating cell uses, so the chain only advances when the loader shifts.
- An optional verify pass re-shifts the same bitstream and compares the returned `ccff_tail` against the shifted bits.

---
 rtl/ccff_bitstream_loader_pkg.sv | 23 ++
 rtl/ccff_bitstream_loader_if.sv | 13 +
 rtl/ccff_bitstream_loader_serializer.sv | 56 +++++
 rtl/ccff_bitstream_loader.sv | 94 +++++++++
 tb/tb_ccff_bitstream_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ccff_state_t;

  // Ceiling log2 used to size counters from elaboration-time constants.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Valid/ready word bus feeding configuration words into the loader.
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 8
) ();

  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/ccff_bitstream_loader_serializer.sv
// Word-to-bit serializer: accepts a word when empty, then shifts it out LSB first.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8,
  parameter int BIT_W     = 4
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  active,
  input  logic                  flush,
  input  logic [BIT_W-1:0]      bit_cnt,
  ccff_bitstream_loader_if.slave wbus,
  output logic                  head,
  output logic                  shift_en
);

  localparam int SCW = clog2(WORD_W + 1);

  logic [WORD_W-1:0] sr;
  logic [SCW-1:0]    sr_cnt;
  logic [SCW-1:0]    load_cnt;
  logic              accept;
  int                remaining;

  // Ready only while empty; shift enable and head come straight from registers.
  assign wbus.word_ready = active && (sr_cnt == '0);
  assign shift_en        = active && (sr_cnt != '0);
  assign head            = shift_en & sr[0];
  assign accept          = wbus.word_ready & wbus.word_valid;

  // Bits to take from the next word: a full word, or only what the chain still needs.
  always_comb begin
    remaining = CHAIN_LEN - int'(bit_cnt);
    load_cnt  = SCW'(WORD_W);
    if (remaining < WORD_W) load_cnt = SCW'(remaining);
  end

  // Load on handshake, otherwise shift one bit per edge; pass end discards leftovers.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      sr     <= '0;
      sr_cnt <= '0;
    end else if (flush) begin
      sr_cnt <= '0;
    end else if (accept) begin
      sr     <= wbus.word_data;
      sr_cnt <= load_cnt;
    end else if (shift_en) begin
      sr     <= sr >> 1;
      sr_cnt <= sr_cnt - SCW'(1);
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: pass FSM, bit counter and optional verify comparator.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 8,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  verify,
  ccff_bitstream_loader_if.slave wbus,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      err_cnt
);

  // bit_cnt must reach CHAIN_LEN even when err_cnt is narrower.
  localparam int BIT_W = clog2(CHAIN_LEN + 1);

  ccff_state_t      state;
  logic             vmode;
  logic [BIT_W-1:0] bit_cnt;
  logic             shift_en;
  logic             head;
  logic             last_shift;
  logic             mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign ccff_head     = head;
  assign ccff_shift_en = shift_en;
  assign last_shift    = shift_en && (bit_cnt == BIT_W'(CHAIN_LEN - 1));
  assign mismatch      = vmode && (ccff_tail != head);

  ccff_word_serializer #(
    .CHAIN_LEN (CHAIN_LEN),
    .WORD_W    (WORD_W),
    .BIT_W     (BIT_W)
  ) u_ser (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .active   (state == LOAD),
    .flush    (last_shift),
    .bit_cnt  (bit_cnt),
    .wbus     (wbus),
    .head     (head),
    .shift_en (shift_en)
  );

  // Pass control: start from IDLE/DONE, count shifts, compare tail in verify mode.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state   <= IDLE;
      vmode   <= 1'b0;
      bit_cnt <= '0;
      err_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vmode   <= verify;
            bit_cnt <= '0;
            err_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (shift_en) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            if (mismatch) err_cnt <= sat_inc(err_cnt);
            if (last_shift) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for the configuration-chain loader with a behavioural chain model.
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;
  always #5 prog_clk = ~prog_clk;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int sel      = 0;
  logic clr    = 1'b0;

  // DUT A: 8-bit chain, with chain model and optional stuck-at-1 tail
  logic start_a = 1'b0, verify_a = 1'b0, stuck_a = 1'b0;
  logic head_a, sen_a, tail_a, busy_a, done_a;
  logic [3:0] err_a;
  logic [7:0] chain_a = '0;
  ccff_bitstream_loader_if #(.WORD_W(8)) bus_a ();
  assign tail_a = stuck_a | chain_a[7];
  ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(8), .CNT_W(4)) dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_a), .verify(verify_a),
    .wbus(bus_a), .ccff_head(head_a), .ccff_shift_en(sen_a), .ccff_tail(tail_a),
    .busy(busy_a), .done(done_a), .err_cnt(err_a));

  // DUT B: 12-bit chain, partial last word
  logic start_b = 1'b0, verify_b = 1'b0, tail_b = 1'b0;
  logic head_b, sen_b, busy_b, done_b;
  logic [3:0] err_b;
  ccff_bitstream_loader_if #(.WORD_W(8)) bus_b ();
  ccff_bitstream_loader #(.CHAIN_LEN(12), .WORD_W(8), .CNT_W(4)) dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_b), .verify(verify_b),
    .wbus(bus_b), .ccff_head(head_b), .ccff_shift_en(sen_b), .ccff_tail(tail_b),
    .busy(busy_b), .done(done_b), .err_cnt(err_b));

  // DUT C: 16-bit chain, 4-bit error counter, tail stuck at 1
  logic start_c = 1'b0, verify_c = 1'b0, tail_c = 1'b1;
  logic head_c, sen_c, busy_c, done_c;
  logic [3:0] err_c;
  ccff_bitstream_loader_if #(.WORD_W(8)) bus_c ();
  ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8), .CNT_W(4)) dut_c (
    .prog_clk(prog_clk), .pReset(pReset), .start(start_c), .verify(verify_c),
    .wbus(bus_c), .ccff_head(head_c), .ccff_shift_en(sen_c), .ccff_tail(tail_c),
    .busy(busy_c), .done(done_c), .err_cnt(err_c));

  // Shift monitors: count shifts, record head bits in shift order, advance chain model
  int cyc = 0, sh_a = 0, sh_b = 0, first_a = 0, last_a = 0;
  logic [31:0] seq_a = '0, seq_b = '0;
  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (sen_a) chain_a <= {chain_a[6:0], head_a};
    if (clr) begin
      sh_a <= 0; seq_a <= '0; sh_b <= 0; seq_b <= '0;
    end else begin
      if (sen_a) begin
        if (sh_a == 0) first_a <= cyc;
        last_a <= cyc;
        if (sh_a < 32) seq_a[sh_a[4:0]] <= head_a;
        sh_a <= sh_a + 1;
      end
      if (sen_b) begin
        if (sh_b < 32) seq_b[sh_b[4:0]] <= head_b;
        sh_b <= sh_b + 1;
      end
    end
  end

  logic cur_ready, cur_done;
  int   cur_sh;
  always_comb begin
    cur_ready = bus_a.word_ready; cur_done = done_a; cur_sh = sh_a;
    if (sel == 1) begin cur_ready = bus_b.word_ready; cur_done = done_b; cur_sh = sh_b; end
    if (sel == 2) begin cur_ready = bus_c.word_ready; cur_done = done_c; cur_sh = 0; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bus(input logic v, input logic [7:0] w);
    bus_a.word_valid = v && (sel == 0); bus_a.word_data = w;
    bus_b.word_valid = v && (sel == 1); bus_b.word_data = w;
    bus_c.word_valid = v && (sel == 2); bus_c.word_data = w;
  endtask

  task automatic pulse_start(input logic v);
    @(negedge prog_clk);
    start_a = (sel == 0); start_b = (sel == 1); start_c = (sel == 2);
    verify_a = v; verify_b = v; verify_c = v;
    @(negedge prog_clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    int n;
    @(negedge prog_clk);
    drive_bus(1'b1, w);
    for (n = 0; n < 50 && !cur_ready; n++) @(negedge prog_clk);
    if (n == 50) check("ready_timeout", 32'd0, 32'd1);
    @(negedge prog_clk);
    drive_bus(1'b0, 8'h00);
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 200 && !cur_done; n++) @(negedge prog_clk);
    if (n == 200) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_sh(input int k);
    int n;
    for (n = 0; n < 200 && cur_sh < k; n++) @(negedge prog_clk);
    if (n == 200) check("shift_timeout", 32'(cur_sh), 32'(k));
  endtask

  task automatic clear_mon();
    @(negedge prog_clk); clr = 1'b1;
    @(negedge prog_clk); clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gap_or;
    drive_bus(1'b0, 8'h00);
    repeat (2) @(negedge prog_clk);
    check("reset_outputs", 32'({busy_a, done_a, bus_a.word_ready, head_a, sen_a, err_a}), 32'd0);
    pReset = 1'b0;
    clear_mon();

    // Load A5 into an 8-bit chain
    pulse_start(1'b0);
    check("t1_busy", 32'(busy_a), 32'd1);
    send_word(8'hA5);
    wait_sh(8);
    check("t1_done", 32'(done_a), 32'd1);
    check("t1_head_seq", seq_a[7:0], 32'hA5);
    check("t1_consecutive", 32'(last_a - first_a), 32'd7);
    check("t1_chain", 32'(chain_a), 32'hA5);

    // Data offered in DONE is not consumed
    @(negedge prog_clk); drive_bus(1'b1, 8'hFF);
    check("done_ready", 32'(bus_a.word_ready), 32'd0);
    repeat (3) @(negedge prog_clk);
    check("done_no_shift", 32'(sh_a), 32'd8);
    drive_bus(1'b0, 8'h00);

    // Verify with matching data
    pulse_start(1'b1);
    check("t2_done_cleared", 32'(done_a), 32'd0);
    send_word(8'hA5);
    wait_done();
    check("t2_err", 32'(err_a), 32'd0);
    check("t2_done", 32'(done_a), 32'd1);

    // Reload, then verify with one-bit difference; a stray start in LOAD must not clear verify mode
    pulse_start(1'b0);
    send_word(8'hA5);
    wait_done();
    pulse_start(1'b1);
    pulse_start(1'b0);
    send_word(8'hA4);
    wait_done();
    check("t3_err", 32'(err_a), 32'd1);

    // Stuck-at-1 tail against all-zero data
    stuck_a = 1'b1;
    pulse_start(1'b1);
    send_word(8'h00);
    wait_done();
    check("t6_err_stuck", 32'(err_a), 32'd8);
    stuck_a = 1'b0;

    // Reset mid-pass, then a full reload
    clear_mon();
    pulse_start(1'b0);
    send_word(8'hA5);
    wait_sh(3);
    pReset = 1'b1;
    #1;
    check("t5_reset_outputs", 32'({busy_a, done_a, bus_a.word_ready, head_a, sen_a, err_a}), 32'd0);
    repeat (2) @(negedge prog_clk);
    pReset = 1'b0;
    clear_mon();
    pulse_start(1'b0);
    send_word(8'h3C);
    wait_done();
    check("t5_shift_count", 32'(sh_a), 32'd8);
    check("t5_head_seq", seq_a[7:0], 32'h3C);
    check("t5_chain", 32'(chain_a), 32'h3C);

    // 12-bit chain with a 5-cycle word gap; upper nibble of word 2 discarded
    sel = 1;
    clear_mon();
    pulse_start(1'b0);
    send_word(8'h3C);
    wait_sh(8);
    gap_or = 1'b0;
    repeat (5) begin
      @(negedge prog_clk);
      gap_or = gap_or | sen_b;
    end
    check("t4_gap_shift_en", 32'(gap_or), 32'd0);
    check("t4_gap_busy", 32'(busy_b), 32'd1);
    send_word(8'hF6);
    wait_done();
    repeat (4) @(negedge prog_clk);
    check("t4_shift_count", 32'(sh_b), 32'd12);
    check("t4_head_seq", seq_b[11:0], 32'h63C);
    check("t4_done", 32'(done_b), 32'd1);

    // 16-bit chain, stuck tail: 4-bit error counter saturates at 15
    sel = 2;
    pulse_start(1'b1);
    send_word(8'h00);
    send_word(8'h00);
    wait_done();
    check("sat_err", 32'(err_c), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
